// File: rtl/vedic_conv_pkg.sv
// Shared types and helpers for the Vedic-multiplier convolution scheduler.
package vedic_conv_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam int OPERAND_W = 8;
    localparam int PROD_W    = 16;

    // Urdhva-Tiryakbhyam base cell: 2x2 product from AND terms and two half adders.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
        logic t0, t1, t2, t3, c1;
        t0 = a[0] & b[0];
        t1 = a[1] & b[0];
        t2 = a[0] & b[1];
        t3 = a[1] & b[1];
        c1 = t1 & t2;
        return {t3 & c1, t3 ^ c1, t1 ^ t2, t0};
    endfunction

endpackage

// File: rtl/vedic_conv_scheduler_mult.sv
// Unsigned 8x8 Vedic multiplier built from 2x2 cells composed into 4x4 and 8x8 blocks.
module Vedic_multiplier_8x8_Combinational
    import vedic_conv_pkg::*;
(
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic [PROD_W-1:0]    p
);

    function automatic logic [7:0] vedic_4x4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] ll, lh, hl, hh;
        ll = {4'b0, vedic_2x2(x[1:0], y[1:0])};
        lh = {4'b0, vedic_2x2(x[1:0], y[3:2])};
        hl = {4'b0, vedic_2x2(x[3:2], y[1:0])};
        hh = {4'b0, vedic_2x2(x[3:2], y[3:2])};
        return ll + ((lh + hl) << 2) + (hh << 4);
    endfunction

    logic [15:0] ll, lh, hl, hh;

    always_comb begin
        ll = {8'b0, vedic_4x4(a[3:0], b[3:0])};
        lh = {8'b0, vedic_4x4(a[3:0], b[7:4])};
        hl = {8'b0, vedic_4x4(a[7:4], b[3:0])};
        hh = {8'b0, vedic_4x4(a[7:4], b[7:4])};
        p  = ll + ((lh + hl) << 4) + (hh << 8);
    end

endmodule

// File: rtl/vedic_conv_scheduler.sv
// FIR convolution sequencer sharing one 8x8 Vedic multiplier across TAPS taps.
// Define VEDIC_MULT_PIPE_EN to register the multiplier output (one extra MAC cycle).
module vedic_conv_scheduler
    import vedic_conv_pkg::*;
#(
    parameter  int TAPS  = 4,
    localparam int ACC_W = 16 + $clog2(TAPS),
    localparam int IDX_W = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coef_we,
    input  logic [IDX_W-1:0] coef_addr,
    input  logic [7:0]       coef_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_data,
    output logic             busy
);

    localparam int K_W = $clog2(TAPS + 1);
`ifdef VEDIC_MULT_PIPE_EN
    localparam logic [K_W-1:0] K_LAST = K_W'(TAPS);
`else
    localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);
`endif

    state_t                state, state_nxt;
    logic [OPERAND_W-1:0]  x [TAPS];
    logic [OPERAND_W-1:0]  c [TAPS];
    logic [ACC_W-1:0]      acc;
    logic [K_W-1:0]        k;
    logic [IDX_W-1:0]      tap;
    logic                  tap_valid;
    logic [OPERAND_W-1:0]  mul_a, mul_b;
    logic [PROD_W-1:0]     prod;
    logic [PROD_W-1:0]     addend;
    logic                  accept;

    always_comb begin
        tap       = k[IDX_W-1:0];
        tap_valid = (k < K_W'(TAPS));
        mul_a     = tap_valid ? x[tap] : '0;
        mul_b     = tap_valid ? c[tap] : '0;
    end

    Vedic_multiplier_8x8_Combinational u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

`ifdef VEDIC_MULT_PIPE_EN
    // prod_q is cleared on accept so the pipe-fill cycle adds zero.
    logic [PROD_W-1:0] prod_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prod_q <= '0;
        else if (accept)
            prod_q <= '0;
        else if (state == MAC)
            prod_q <= prod;
    end

    assign addend = prod_q;
`else
    assign addend = prod;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid)
                    state_nxt = MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (k == K_LAST)
                    state_nxt = OUT;
            end
            OUT: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                if (m_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && s_valid;
    assign m_data = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
            acc <= '0;
            k   <= '0;
        end else begin
            // Coefficient write lands on the accept edge too, so that sample sees it.
            if (state == IDLE && coef_we && int'(coef_addr) < TAPS)
                c[coef_addr] <= coef_data;
            if (accept) begin
                x[0] <= s_data;
                for (int unsigned i = 1; i < TAPS; i++)
                    x[i] <= x[i-1];
                acc <= '0;
                k   <= '0;
            end else if (state == MAC) begin
                acc <= acc + ACC_W'(addend);
                k   <= k + K_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vedic_conv_scheduler.sv
// Self-checking bench for vedic_conv_scheduler against a sliding-window dot-product model.
module tb_vedic_conv_scheduler;

    localparam int TAPS  = 4;
    localparam int ACC_W = 16 + $clog2(TAPS);
`ifdef VEDIC_MULT_PIPE_EN
    localparam int LAT    = TAPS + 2;
    localparam int PERIOD = TAPS + 3;
`else
    localparam int LAT    = TAPS + 1;
    localparam int PERIOD = TAPS + 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             coef_we = 1'b0;
    logic [1:0]       coef_addr = '0;
    logic [7:0]       coef_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [ACC_W-1:0] m_data;
    logic             busy;

    int tests = 0;
    int fails = 0;

    int mx [TAPS];
    int mc [TAPS];

    always #5 clk = ~clk;

    vedic_conv_scheduler #(.TAPS(TAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy)
    );

    // Reference: newest sample at index 0, y = sum x[k]*c[k].
    function automatic int model_y();
        int s = 0;
        for (int i = 0; i < TAPS; i++)
            s += mx[i] * mc[i];
        return s;
    endfunction

    task automatic model_push(input int d);
        for (int i = TAPS - 1; i > 0; i--)
            mx[i] = mx[i-1];
        mx[0] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) begin
            mx[i] = 0;
            mc[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic write_coef(input int a, input int d, input bit honored);
        coef_we   = 1'b1;
        coef_addr = 2'(a);
        coef_data = 8'(d);
        @(negedge clk);
        coef_we = 1'b0;
        if (honored)
            mc[a] = d;
    endtask

    task automatic send(input int d);
        int n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            tests++;
            fails++;
            $display("FAIL send_wait: s_ready=%0d after %0d cycles, required 1", s_ready, n);
        end
        s_valid = 1'b1;
        s_data  = 8'(d);
        @(negedge clk);
        s_valid = 1'b0;
        model_push(d);
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!m_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!m_valid) begin
            tests++;
            fails++;
            $display("FAIL result_wait: m_valid=0 after %0d cycles, required 1", lat);
        end
    endtask

    task automatic handshake();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: m_valid=%0d busy=%0d, required 0 0", m_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || m_data !== '0) begin
            fails++;
            $display("FAIL reset_state: s_ready=%0d m_valid=%0d busy=%0d m_data=%0d, required 1 0 0 0",
                     s_ready, m_valid, busy, m_data);
        end
        send(77);
        wait_result(lat);
        tests++;
        if (m_data !== ACC_W'(0)) begin
            fails++;
            $display("FAIL reset_coef_zero: m_data=%0d, required 0", m_data);
        end
        handshake();
    endtask

    task automatic test_basic();
        int samp [4] = '{10, 20, 30, 40};
        int want [4] = '{10, 40, 100, 200};
        int lat;
        do_reset();
        for (int i = 0; i < 4; i++)
            write_coef(i, i + 1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(samp[i]);
            wait_result(lat);
            tests++;
            if (lat !== LAT) begin
                fails++;
                $display("FAIL basic_latency[%0d]: m_valid in cycle %0d, required %0d", i, lat, LAT);
            end
            tests++;
            if (m_data !== ACC_W'(want[i])) begin
                fails++;
                $display("FAIL basic_result[%0d]: m_data=%0d, required %0d", i, m_data, want[i]);
            end
            handshake();
            tests++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
                fails++;
                $display("FAIL basic_release[%0d]: m_valid=%0d s_ready=%0d, required 0 1", i, m_valid, s_ready);
            end
        end
    endtask

    task automatic test_max();
        int lat;
        do_reset();
        for (int i = 0; i < TAPS; i++)
            write_coef(i, 255, 1'b1);
        for (int i = 0; i < TAPS; i++) begin
            send(255);
            wait_result(lat);
            tests++;
            if (m_data !== ACC_W'(model_y())) begin
                fails++;
                $display("FAIL max_result[%0d]: m_data=%0d, required %0d", i, m_data, model_y());
            end
            handshake();
        end
        tests++;
        if (model_y() != 260100) begin
            fails++;
            $display("FAIL max_model: model=%0d, required 260100", model_y());
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [ACC_W-1:0] cap;
        send(int'($urandom_range(0, 255)));
        wait_result(lat);
        cap = m_data;
        tests++;
        if (cap !== ACC_W'(model_y())) begin
            fails++;
            $display("FAIL bp_result: m_data=%0d, required %0d", cap, model_y());
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b1 || m_data !== cap || s_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: m_valid=%0d m_data=%0d s_ready=%0d busy=%0d, required 1 %0d 0 1",
                         i, m_valid, m_data, s_ready, busy, cap);
            end
        end
        handshake();
        tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: m_valid=%0d s_ready=%0d busy=%0d, required 0 1 0", m_valid, s_ready, busy);
        end
    endtask

    task automatic test_coef_ignore();
        int lat;
        write_coef(0, 3, 1'b1);
        send(int'($urandom_range(1, 255)));
        write_coef(0, 9, 1'b0);
        wait_result(lat);
        tests++;
        if (m_data !== ACC_W'(model_y())) begin
            fails++;
            $display("FAIL coef_ignore_mac: m_data=%0d, required %0d", m_data, model_y());
        end
        write_coef(0, 9, 1'b0);
        handshake();
        send(int'($urandom_range(1, 255)));
        wait_result(lat);
        tests++;
        if (m_data !== ACC_W'(model_y())) begin
            fails++;
            $display("FAIL coef_ignore_next: m_data=%0d, required %0d", m_data, model_y());
        end
        handshake();
    endtask

    task automatic test_abort();
        int lat;
        send(int'($urandom_range(1, 255)));
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_now: m_valid=%0d busy=%0d, required 0 0", m_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < TAPS + 3; i++) begin
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_quiet[%0d]: m_valid=%0d busy=%0d, required 0 0", i, m_valid, busy);
            end
        end
        write_coef(0, 1, 1'b1);
        write_coef(1, 0, 1'b1);
        write_coef(2, 0, 1'b1);
        write_coef(3, 0, 1'b1);
        send(50);
        wait_result(lat);
        tests++;
        if (m_data !== ACC_W'(50)) begin
            fails++;
            $display("FAIL abort_next: m_data=%0d, required 50", m_data);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int q[$];
        int last = -1;
        int d;
        for (int i = 0; i < TAPS; i++)
            write_coef(i, int'($urandom_range(0, 255)), 1'b1);
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int cyc = 0; cyc < 6 * PERIOD; cyc++) begin
            if (m_valid) begin
                tests++;
                if (q.size() == 0 || m_data !== ACC_W'(q[0])) begin
                    fails++;
                    $display("FAIL b2b_result: m_data=%0d, required %0d", m_data, (q.size() > 0) ? q[0] : -1);
                end
                if (q.size() > 0)
                    void'(q.pop_front());
            end
            if (s_ready) begin
                if (last >= 0) begin
                    tests++;
                    if (cyc - last != PERIOD) begin
                        fails++;
                        $display("FAIL b2b_period: accept gap %0d cycles, required %0d", cyc - last, PERIOD);
                    end
                end
                last = cyc;
                d = int'($urandom_range(0, 255));
                s_data = 8'(d);
                model_push(d);
                q.push_back(model_y());
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        for (int n = 0; n < 3 * PERIOD && q.size() > 0; n++) begin
            if (m_valid) begin
                tests++;
                if (m_data !== ACC_W'(q[0])) begin
                    fails++;
                    $display("FAIL b2b_drain_result: m_data=%0d, required %0d", m_data, q[0]);
                end
                void'(q.pop_front());
            end
            @(negedge clk);
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL b2b_drain: %0d results missing, required 0", q.size());
        end
        m_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 2) == 0)
                write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)), 1'b1);
            send(int'($urandom_range(0, 255)));
            wait_result(lat);
            tests++;
            if (lat !== LAT || m_data !== ACC_W'(model_y())) begin
                fails++;
                $display("FAIL random[%0d]: latency=%0d m_data=%0d, required %0d %0d",
                         it, lat, m_data, LAT, model_y());
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_coef_ignore();
        test_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vedic_conv_scheduler.md
# vedic_conv_scheduler

Sequencing controller for 1-D FIR convolution that time-multiplexes a single 8x8 Vedic multiplier across all kernel taps. It accepts one 8-bit sample per handshake, shifts it into a TAPS-deep sample window, and multiply-accumulates the window against stored coefficients, one tap per cycle. It then presents the convolution result on a valid/ready output. It sits between the sample stream source and the downstream signal-processing stage.

## Interface
- TAPS, 4, kernel length; legal range 2..16.
- ACC_W, derived localparam = 16 + $clog2(TAPS), accumulator and result width.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  coefficient index.
- coef_data  in  8  unsigned coefficient value.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready.
- s_data  in  8  unsigned sample.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- m_data  out  ACC_W  unsigned convolution result.
- busy  out  1  high in MAC and OUT states.

## Operation
- FSM states: IDLE, MAC, OUT.
- IDLE: s_ready=1. On s_valid&&s_ready: x[0]<=s_data, x[i]<=x[i-1] for i in 1..TAPS-1, acc<=0, k<=0, go MAC.
- MAC: one multiplier operation per cycle, x[k]*c[k] (unsigned 8x8→16). acc<=acc+product. k increments; after the k=TAPS-1 product is accumulated, go OUT.
- OUT: m_valid=1, m_data=acc held stable. On m_valid&&m_ready go IDLE.
- Result: y = sum over k of x[k]*c[k]. x[0] is the newest sample. Unfilled window slots are 0.
- Arithmetic: all unsigned. ACC_W holds TAPS*255*255 exactly, so no overflow and no saturation logic.
- Coefficient writes: honored only in IDLE, taking effect on the next edge; ignored in MAC/OUT. A write in the same cycle as a sample accept is honored and is used by that sample's computation.
- s_ready=0 in MAC and OUT. Samples are never dropped; the source stalls.

## Timing
- Reset values: state IDLE, m_valid=0, m_data=0, busy=0, s_ready=1 after reset deasserts, acc=0, k=0, all x[] and c[] =0.
- Reset asserted mid-MAC or mid-OUT aborts immediately. The pending result is discarded and no m_valid is produced.
- Latency: sample accepted in cycle 0 → m_valid first high in cycle TAPS+1.
- Throughput with m_ready held high: one sample per TAPS+2 cycles.
- m_valid, once high, stays high with m_data stable until the handshake.

## Configuration
- VEDIC_MULT_PIPE_EN defined: a register stage is inserted on the multiplier output. MAC lasts TAPS+1 cycles: the first cycle fills the pipe and the last cycle drains it. Latency becomes TAPS+2 and throughput one sample per TAPS+3 cycles. Results are identical.
- VEDIC_MULT_PIPE_EN undefined: the product is accumulated combinationally in the same cycle, with timing as stated above.

## Structure
- Package vedic_conv_pkg: state enum typedef (IDLE, MAC, OUT), OPERAND_W=8, PROD_W=16.
- One sub-module instance: Vedic_multiplier_8x8_Combinational, inputs muxed from x[k] and c[k].
- Sample window, coefficient registers, accumulator, tap counter and FSM live in this module.

## Test plan
- TAPS=4, coefficients {1,2,3,4}, samples 10,20,30,40 → m_data 10, 40, 100, 200 in order.
- All coefficients 255, four samples of 255 → fourth result 260100 (18-bit, no wrap).
- m_ready low for 5 cycles in OUT → m_valid and m_data hold, s_ready=0, busy=1. Raise m_ready → single transfer, then IDLE.
- coef_we to address 0 with value 9 during MAC → ignored; the current and next results use the old c[0].
- rst pulsed during the 2nd MAC cycle → m_valid stays 0, busy=0. The next sample of 50 with coefficients reloaded to {1,0,0,0} → m_data 50.
- Latency: TAPS=4, accept in cycle 0 → m_valid in cycle 5 (cycle 6 with VEDIC_MULT_PIPE_EN).
